fetch_ctrl: RTL

- Sequences the program counter register and the instruction-memory fetch port for the core front end.
- Issues one instruction fetch at a time at the current PC and hands the fetched word to decode over a valid/ready handshake.
- Advances the PC by 2 or 4 only when decode accepts an instruction.
- Applies trap and branch redirects by loading the PC directly.

---
 rtl/fetch_ctrl.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: front-end fetch sequencer.
// Presents one instruction-memory request at a time at the current PC and
// holds the returned word for decode over a valid/ready handshake. The PC
// register itself is external; this block steers it through step_size
// (increment applied at the next edge, 0 = hold) and set_pc/set_pc_value
// (direct load used for boot, traps and branch redirects).
//
// Ports:
//   clk, rstn                  clock, asynchronous active-low reset
//   pc_value                   current PC from the PC register
//   step_size, set_pc(_value)  PC update controls for the next edge
//   imem_req_*                 fetch request channel (valid/ready/addr)
//   imem_rsp_*                 fetch response (valid pulse, data, fault)
//   inst_*                     instruction handed to decode (valid/ready)
//   trap_*, redirect_*         flush requests; trap has priority
//   halt_req, halted           stop fetching / controller parked in IDLE
module fetch_ctrl #(
  parameter int unsigned           XLEN      = 32,
  parameter logic [XLEN-1:0]       BOOT_ADDR = 32'h0000_0000,
  parameter bit                    C_EXT     = 1'b1
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [XLEN-1:0] pc_value,
  output logic [7:0]      step_size,
  output logic            set_pc,
  output logic [XLEN-1:0] set_pc_value,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            imem_rsp_err,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst_data,
  output logic [XLEN-1:0] inst_pc,
  output logic            inst_err,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_vector,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            halt_req,
  output logic            halted
);

  typedef enum logic [2:0] {
    ST_BOOT  = 3'd0,
    ST_FETCH = 3'd1,
    ST_WAIT  = 3'd2,
    ST_HAND  = 3'd3,
    ST_DRAIN = 3'd4,
    ST_IDLE  = 3'd5
  } state_e;

  state_e state_q, state_d;

  // Set while a request has been presented but not yet accepted; a halt must
  // not withdraw such a request, only a flush may.
  logic req_hold_q, req_hold_d;

  logic flush_s;
  logic latch_s;
  logic [7:0] step_amt_s;

  assign flush_s = trap_valid | redirect_valid;

  // Instruction length: 16-bit encodings have low bits other than 2'b11.
  always_comb begin
    if (!C_EXT || (inst_data[1:0] == 2'b11)) begin
      step_amt_s = 8'd4;
    end else begin
      step_amt_s = 8'd2;
    end
  end

  // Next-state and output decode from state and inputs.
  always_comb begin
    state_d        = state_q;
    req_hold_d     = 1'b0;
    latch_s        = 1'b0;
    step_size      = 8'd0;
    set_pc         = 1'b0;
    set_pc_value   = '0;
    imem_req_valid = 1'b0;
    imem_req_addr  = pc_value;
    inst_valid     = 1'b0;
    halted         = 1'b0;

    case (state_q)
      ST_BOOT: begin
        // Flushes are ignored here; the boot load always wins.
        set_pc       = 1'b1;
        set_pc_value = BOOT_ADDR;
        state_d      = ST_FETCH;
      end

      ST_FETCH: begin
        if (halt_req && !req_hold_q && !flush_s) begin
          state_d = ST_IDLE;
        end else begin
          imem_req_valid = 1'b1;
          if (imem_req_ready) begin
            // An accepted request that is flushed still owes a response.
            state_d = flush_s ? ST_DRAIN : ST_WAIT;
          end else begin
            state_d    = ST_FETCH;
            req_hold_d = !flush_s;
          end
        end
      end

      ST_WAIT: begin
        if (imem_rsp_valid) begin
          if (flush_s) begin
            state_d = ST_FETCH;
          end else begin
            latch_s = 1'b1;
            state_d = ST_HAND;
          end
        end else begin
          state_d = flush_s ? ST_DRAIN : ST_WAIT;
        end
      end

      ST_HAND: begin
        inst_valid = 1'b1;
        if (flush_s) begin
          // Decode may still take the word this cycle; the step is dropped.
          state_d = ST_FETCH;
        end else if (inst_ready) begin
          step_size = step_amt_s;
          state_d   = halt_req ? ST_IDLE : ST_FETCH;
        end else begin
          state_d = ST_HAND;
        end
      end

      ST_DRAIN: begin
        // The outstanding response is consumed even in a flush cycle, so a
        // flush here cannot strand the controller waiting forever.
        if (imem_rsp_valid) begin
          state_d = ST_FETCH;
        end else begin
          state_d = ST_DRAIN;
        end
      end

      ST_IDLE: begin
        halted = 1'b1;
        if (!halt_req && !flush_s) begin
          state_d = ST_FETCH;
        end else begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_BOOT;
      end
    endcase

    if (flush_s && (state_q != ST_BOOT)) begin
      set_pc       = 1'b1;
      step_size    = 8'd0;
      set_pc_value = trap_valid ? trap_vector : redirect_pc;
    end else begin
      set_pc       = set_pc;
    end
  end

  // State register and request-hold flag.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_BOOT;
      req_hold_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_hold_q <= req_hold_d;
    end
  end

  // Capture the fetched word, its fault tag and its address.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      inst_data <= 32'd0;
      inst_pc   <= '0;
      inst_err  <= 1'b0;
    end else if (latch_s) begin
      inst_data <= imem_rsp_data;
      inst_pc   <= pc_value;
      inst_err  <= imem_rsp_err;
    end else begin
      inst_data <= inst_data;
      inst_pc   <= inst_pc;
      inst_err  <= inst_err;
    end
  end

endmodule
